// File: rtl/fifo_gen2.sv
// fifo_gen2: single-clock FIFO with threshold flags, a RUN/PAUSE flow-control FSM and an error flag.
// Define FIFO_STICKY_ERR_EN to make fifo_error sticky until err_clear; otherwise it pulses for one cycle.
module fifo_gen2 #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 read,
  input  logic [ADDR_SIZE:0]   th_almost_full,
  input  logic [ADDR_SIZE:0]   th_almost_empty,
  input  logic                 err_clear,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [ADDR_SIZE:0]   count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 fifo_pause,
  output logic                 fifo_error
);

  localparam int DEPTH    = 1 << ADDR_SIZE;
  localparam int CNT_SIZE = ADDR_SIZE + 1;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } pause_state_t;

  logic [DATA_SIZE-1:0] mem_reg [DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_reg;
  logic [ADDR_SIZE-1:0] wr_ptr_next;
  logic [ADDR_SIZE-1:0] rd_ptr_reg;
  logic [ADDR_SIZE-1:0] rd_ptr_next;
  logic [CNT_SIZE-1:0]  count_reg;
  logic [CNT_SIZE-1:0]  count_next;
  logic [DATA_SIZE-1:0] data_out_reg;
  logic                 data_valid_reg;
  logic                 error_reg;
  logic                 error_next;
  pause_state_t         state_reg;
  pause_state_t         state_next;

  logic empty_flag;
  logic full_flag;
  logic wr_en;
  logic rd_en;
  logic wr_reject;
  logic rd_reject;
  logic rejected;

  // Status flags come straight from the registered count so they never glitch on request inputs.
  assign empty_flag = (count_reg == '0);
  assign full_flag  = (count_reg == CNT_SIZE'(DEPTH));

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign wr_en     = write && (!full_flag || read);
  assign rd_en     = read && !empty_flag;
  assign wr_reject = write && full_flag && !read;
  assign rd_reject = read && empty_flag && !write;
  assign rejected  = wr_reject || rd_reject;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + ADDR_SIZE'(1);
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + ADDR_SIZE'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + CNT_SIZE'(1);
      2'b01:   count_next = count_reg - CNT_SIZE'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pause decisions look ahead at next-state count; the set condition takes priority.
  always_comb begin
    state_next = state_reg;
    if (count_next >= th_almost_full) begin
      state_next = PAUSE;
    end else if (count_next <= th_almost_empty) begin
      state_next = RUN;
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  always_comb begin
    error_next = error_reg;
    if (rejected) begin
      error_next = 1'b1;
    end else if (err_clear) begin
      error_next = 1'b0;
    end
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign error_next       = rejected;
`endif

  // Storage has no reset so it maps onto block RAM; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (reset_L && wr_en) begin
      mem_reg[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      error_reg      <= 1'b0;
      state_reg      <= RUN;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      data_valid_reg <= rd_en;
      error_reg      <= error_next;
      state_reg      <= state_next;
      if (rd_en) begin
        data_out_reg <= mem_reg[rd_ptr_reg];
      end
    end
  end

  assign data_out     = data_out_reg;
  assign data_valid   = data_valid_reg;
  assign count        = count_reg;
  assign fifo_empty   = empty_flag;
  assign fifo_full    = full_flag;
  assign almost_full  = (count_reg >= th_almost_full);
  assign almost_empty = !empty_flag && (count_reg <= th_almost_empty);
  assign fifo_pause   = (state_reg == PAUSE);
  assign fifo_error   = error_reg;

endmodule

// File: doc/fifo_gen2.md
FIFO_GEN2 -- requirements
Module: fifo_gen2

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 12, word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 3, pointer width; depth DEPTH = 2**ADDR_SIZE.
REQ-003 SHALL have derived localparam CNT_SIZE = ADDR_SIZE+1, the width of the occupancy count and the thresholds.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_L  in  1  synchronous, active-low reset.
REQ-006 write  in  1  write request; data_in sampled same edge.
REQ-007 data_in  in  DATA_SIZE  write data.
REQ-008 read  in  1  read request.
REQ-009 th_almost_full  in  CNT_SIZE  almost-full / pause-set threshold.
REQ-010 th_almost_empty  in  CNT_SIZE  almost-empty / pause-release threshold.
REQ-011 err_clear  in  1  clears sticky error (sticky build only, else ignored).
REQ-012 data_out  out  DATA_SIZE  registered read data.
REQ-013 data_valid  out  1  one-cycle strobe, data_out updated.
REQ-014 count  out  CNT_SIZE  occupancy, 0..DEPTH.
REQ-015 fifo_empty, fifo_full, almost_empty, almost_full, fifo_pause, fifo_error  out  1 each  status.

Function
REQ-016 Storage SHALL be an internal DEPTH x DATA_SIZE array; write/read pointers SHALL wrap modulo DEPTH.
REQ-017 Write accepted iff write && (!fifo_full || read); read accepted iff read && !fifo_empty.
REQ-018 Both accepted: count unchanged, both pointers advance (includes full case); write-only: count+1; read-only: count-1.
REQ-019 Read on empty with concurrent write: read ignored, write accepted, no error, data_valid stays 0 (no bypass).
REQ-020 Read latency one cycle: accepted read at edge N -> data_out = oldest word and data_valid = 1 after edge N; data_out holds otherwise, data_valid = 0.
REQ-021 fifo_empty = (count==0); fifo_full = (count==DEPTH); almost_full = (count >= th_almost_full); almost_empty = (count != 0 && count <= th_almost_empty); all decoded from the count register.
REQ-022 fifo_pause SHALL be a two-state FSM RUN/PAUSE evaluated on next-state count: RUN->PAUSE when next count >= th_almost_full; PAUSE->RUN when next count <= th_almost_empty; else hold; set wins if both true.
REQ-023 Rejected request (write on full without read; read on empty without write) SHALL raise fifo_error the cycle after the edge; pointers, count and data unaffected.

Reset
REQ-024 While reset_L = 0 at an edge: pointers 0, count 0, data_out 0, data_valid 0, FSM RUN (fifo_pause 0), fifo_error 0, fifo_empty 1, other flags 0.
REQ-025 Requests at a reset edge SHALL be ignored; reset mid-operation discards contents (array not cleared, unreadable).

Configuration
REQ-026 Macro FIFO_STICKY_ERR_EN defined: fifo_error stays 1 until an edge with err_clear = 1 and no new error; new error with err_clear same edge -> stays 1.
REQ-027 FIFO_STICKY_ERR_EN undefined: fifo_error is a one-cycle pulse per rejected request; err_clear has no effect.

Verification (DATA_SIZE=12, ADDR_SIZE=3, th_almost_full=6, th_almost_empty=2)
REQ-028 Reset, write 0x001..0x008 on 8 edges -> count 8, fifo_full 1, almost_full from count 6, fifo_pause 1 at edge of 6th write, fifo_error 0.
REQ-029 Then read 8 -> data_out 0x001..0x008 in order with data_valid each cycle, fifo_pause 0 at edge reaching count 2, fifo_empty 1 at end.
REQ-030 Full, write=1 read=0 -> fifo_error 1 one cycle (sticky build: holds until err_clear), count 8, contents intact.
REQ-031 Full, write=1 read=1 data_in 0x0AA -> count 8, data_out = oldest word, no error; 0x0AA read out 8th.
REQ-032 Empty, read only -> fifo_error 1; empty, read+write 0x055 -> no error, count 1, data_valid 0.
REQ-033 20 interleaved writes/reads across pointer wrap -> output sequence equals input sequence, count never exceeds 8.
